// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus instruction-fetch sequencer feeding decode
// through a one-entry valid/stall slot, with branch redirect and misalignment flag.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err
);
    typedef enum logic [1:0] {BOOT, FETCH, FLUSH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pend_q, pend_d, instr_q, instr_d, ipc_q, ipc_d, tgt;
    logic        valid_q, valid_d, mis_q, mis_d;

    assign tgt          = {branch_target[31:2], 2'b00};
    assign pc           = pc_q;
    assign imem_req     = (state_q == FETCH) || (state_q == FLUSH);
    assign if_valid     = valid_q;
    assign if_instr     = instr_q;
    assign if_pc        = ipc_q;
    assign misalign_err = mis_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        mis_d   = mis_q | (branch_taken & (|branch_target[1:0]));
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (imem_ack && !branch_taken) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = HOLD;
                end else if (imem_ack) begin
                    pc_d = tgt;
                end else if (branch_taken) begin
                    pend_d  = tgt;
                    state_d = FLUSH;
                end
            end
            // the in-flight word belongs to the old path; wait for it, then drop it
            FLUSH: begin
                if (imem_ack) begin
                    pc_d    = branch_taken ? tgt : pend_q;
                    state_d = FETCH;
                end else if (branch_taken) begin
                    pend_d = tgt;
                end
            end
            HOLD: begin
                if (branch_taken || !stall) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                    pc_d    = branch_taken ? tgt : pc_q;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus with a scoreboard queue per DUT; monitors pop
// an expected {instr, pc} pair each time a new instruction appears in the slot.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } item_t;
    item_t qa[$];
    item_t qb[$];

    logic        a_reset = 1'b1, a_ack = 1'b0, a_stall = 1'b0, a_br = 1'b0;
    logic [31:0] a_rdata = '0, a_tgt = '0, a_pc, a_pp4, a_instr, a_ipc;
    logic        a_req, a_valid, a_mis;
    assign a_pp4 = a_pc + 32'd4;

    logic        b_reset = 1'b1, b_ack = 1'b0, b_stall = 1'b0, b_br = 1'b0;
    logic [31:0] b_rdata = '0, b_tgt = '0, b_pc, b_pp4, b_instr, b_ipc;
    logic        b_req, b_valid, b_mis;
    assign b_pp4 = b_pc + 32'd4;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset(a_reset), .pc(a_pc), .pc_plus4(a_pp4), .imem_req(a_req),
        .imem_ack(a_ack), .imem_rdata(a_rdata), .stall(a_stall), .branch_taken(a_br),
        .branch_target(a_tgt), .if_valid(a_valid), .if_instr(a_instr), .if_pc(a_ipc),
        .misalign_err(a_mis));

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(b_reset), .pc(b_pc), .pc_plus4(b_pp4), .imem_req(b_req),
        .imem_ack(b_ack), .imem_rdata(b_rdata), .stall(b_stall), .branch_taken(b_br),
        .branch_target(b_tgt), .if_valid(b_valid), .if_instr(b_instr), .if_pc(b_ipc),
        .misalign_err(b_mis));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc, input logic req, input logic v);
        chk({tag, " pc"}, a_pc, pc);
        chk({tag, " req"}, {31'b0, a_req}, {31'b0, req});
        chk({tag, " if_valid"}, {31'b0, a_valid}, {31'b0, v});
    endtask

    logic a_last = 1'b0, b_last = 1'b0;
    always @(negedge clk) begin
        item_t e;
        if (a_valid && !a_last) begin
            if (qa.size() == 0) chk("A unexpected if_valid", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("A if_instr", a_instr, e.instr);
                chk("A if_pc", a_ipc, e.pc);
            end
        end
        if (b_valid && !b_last) begin
            if (qb.size() == 0) chk("B unexpected if_valid", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("B if_instr", b_instr, e.instr);
                chk("B if_pc", b_ipc, e.pc);
            end
        end
        a_last <= a_valid;
        b_last <= b_valid;
    end

    initial begin
        step(); step();
        chk_a("reset", 32'h0, 1'b0, 1'b0);
        chk("reset mis", {31'b0, a_mis}, 32'd0);
        chk("reset if_instr", a_instr, 32'h0);
        chk("reset if_pc", a_ipc, 32'h0);
        // 1: boot then first fetch
        a_reset = 1'b0;
        chk("boot req", {31'b0, a_req}, 32'd0);
        step();
        chk_a("t1 fetch", 32'h0, 1'b1, 1'b0);
        a_ack = 1'b1; a_rdata = 32'h8C01_0004; qa.push_back({32'h8C01_0004, 32'h0});
        step();
        a_ack = 1'b0;
        chk_a("t1 hold", 32'h4, 1'b0, 1'b1);
        // 2: stall holds the slot
        a_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("t2 stall", 32'h4, 1'b0, 1'b1);
        end
        a_stall = 1'b0;
        step();
        chk_a("t2 release", 32'h4, 1'b1, 1'b0);
        a_ack = 1'b1; a_rdata = 32'h1111_0004; qa.push_back({32'h1111_0004, 32'h4});
        step();
        a_ack = 1'b0;
        chk_a("t2 hold", 32'h8, 1'b0, 1'b1);
        step();
        chk_a("t3 fetch", 32'h8, 1'b1, 1'b0);
        // 3: branch with request outstanding -> flush
        a_br = 1'b1; a_tgt = 32'h100;
        step();
        a_br = 1'b0;
        chk_a("t3 flush", 32'h8, 1'b1, 1'b0);
        step();
        chk_a("t3 flush2", 32'h8, 1'b1, 1'b0);
        a_ack = 1'b1; a_rdata = 32'hDEAD_BEEF;
        step();
        a_ack = 1'b0;
        chk_a("t3 redirect", 32'h100, 1'b1, 1'b0);
        // 4: branch overrides stall in HOLD
        a_ack = 1'b1; a_rdata = 32'h2222_0100; qa.push_back({32'h2222_0100, 32'h100});
        step();
        a_ack = 1'b0;
        chk_a("t4 hold", 32'h104, 1'b0, 1'b1);
        a_stall = 1'b1; a_br = 1'b1; a_tgt = 32'h40;
        step();
        a_stall = 1'b0; a_br = 1'b0;
        chk_a("t4 branch", 32'h40, 1'b1, 1'b0);
        // 5: misaligned target with ack in FETCH
        a_ack = 1'b1; a_br = 1'b1; a_tgt = 32'h102;
        step();
        chk_a("t5 misalign", 32'h100, 1'b1, 1'b0);
        chk("t5 mis set", {31'b0, a_mis}, 32'd1);
        a_tgt = 32'h200;
        step();
        a_br = 1'b0; a_rdata = 32'h3333_0200; qa.push_back({32'h3333_0200, 32'h200});
        chk_a("t5 aligned", 32'h200, 1'b1, 1'b0);
        chk("t5 mis sticky", {31'b0, a_mis}, 32'd1);
        step();
        a_ack = 1'b0;
        chk_a("t5 hold", 32'h204, 1'b0, 1'b1);
        step();
        chk_a("t5 fetch", 32'h204, 1'b1, 1'b0);
        // latest redirect during flush wins
        a_br = 1'b1; a_tgt = 32'h300;
        step();
        a_tgt = 32'h400;
        step();
        a_br = 1'b0; a_ack = 1'b1;
        chk_a("flush pend", 32'h204, 1'b1, 1'b0);
        step();
        a_ack = 1'b0;
        chk_a("flush latest", 32'h400, 1'b1, 1'b0);
        // branch coinciding with the flush ack takes priority over pend
        a_br = 1'b1; a_tgt = 32'h500;
        step();
        a_tgt = 32'h600; a_ack = 1'b1;
        step();
        a_br = 1'b0; a_rdata = 32'h4444_0600; qa.push_back({32'h4444_0600, 32'h600});
        chk_a("flush ack br", 32'h600, 1'b1, 1'b0);
        step();
        a_ack = 1'b0;
        chk_a("t5 hold2", 32'h604, 1'b0, 1'b1);
        chk("t5 mis still", {31'b0, a_mis}, 32'd1);
        // async reset mid-cycle while holding a live slot
        #2 a_reset = 1'b1;
        #1;
        chk_a("A async rst", 32'h0, 1'b0, 1'b0);
        chk("A rst mis", {31'b0, a_mis}, 32'd0);
        chk("A rst if_instr", a_instr, 32'h0);
        // 6: wrap-around PC on the second instance
        step();
        b_reset = 1'b0;
        chk("B boot pc", b_pc, 32'hFFFF_FFFC);
        step();
        chk("B fetch req", {31'b0, b_req}, 32'd1);
        b_ack = 1'b1; b_rdata = 32'h0000_0013; qb.push_back({32'h0000_0013, 32'hFFFF_FFFC});
        step();
        b_ack = 1'b0;
        chk("B wrap pc", b_pc, 32'h0);
        chk("B hold valid", {31'b0, b_valid}, 32'd1);
        step();
        chk("B fetch pc", b_pc, 32'h0);
        b_br = 1'b1; b_tgt = 32'h80;
        step();
        b_br = 1'b0;
        chk("B flush req", {31'b0, b_req}, 32'd1);
        #2 b_reset = 1'b1;
        #1;
        chk("B rst req", {31'b0, b_req}, 32'd0);
        chk("B rst valid", {31'b0, b_valid}, 32'd0);
        chk("B rst pc", b_pc, 32'hFFFF_FFFC);
        step(); step();
        chk("A queue drained", qa.size(), 32'd0);
        chk("B queue drained", qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
